// File: rtl/lsu_ctrl.sv
// Load/store initiator: word-aligned memory accesses with byte enables, aligned and extended load data.
// Latency 3 cycles aligned, 4 split, 1 on error; req_ready only in IDLE, so requests wait while busy.
module lsu_ctrl #(
  parameter int DM_ADDRESS       = 9,
  parameter int DATA_W           = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, FIN} state_t;

  state_t                  state_q, state_d;
  logic                    is_load_q, is_load_d;
  logic [2:0]              f3_q, f3_d;
  logic [DM_ADDRESS-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       lo_q, lo_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;

  logic                    unused_addr;
  assign unused_addr = ^addr[31:DM_ADDRESS];

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
  function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   crosses = 1'b0;
      2'b01:   crosses = (off == 2'b11);
      default: crosses = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  logic f3_legal, req_bad;
  assign f3_legal = (funct3[1:0] != 2'b11) &&
                    (is_store ? !funct3[2] : !(funct3[2] && funct3[1]));
  assign req_bad  = (is_load && is_store) || !f3_legal ||
                    (!SPLIT_MISALIGNED && crosses(funct3, addr[1:0]));

  logic [1:0]              off_q;
  logic                    cross_q;
  logic [DM_ADDRESS-1:0]   base_addr;
  logic [7:0]              be_wide;
  logic [2*DATA_W-1:0]     wd_wide;
  logic [2*DATA_W-1:0]     rd_pair;
  logic [DATA_W-1:0]       rd_sh;
  logic [DATA_W-1:0]       ld_res;

  assign off_q     = addr_q[1:0];
  assign cross_q   = crosses(f3_q, off_q);
  assign base_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
  assign be_wide   = {4'b0000, size_mask(f3_q)} << off_q;
  assign wd_wide   = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
  // Split loads: low word was captured in ACC1, the word arriving in FIN is the high one.
  assign rd_pair   = cross_q ? {mem_rdata, lo_q} : {{DATA_W{1'b0}}, mem_rdata};
  assign rd_sh     = DATA_W'(rd_pair >> {off_q, 3'b000});

  always_comb begin
    case (f3_q)
      3'b000:  ld_res = {{(DATA_W-8){rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld_res = {{(DATA_W-16){rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  ld_res = {{(DATA_W-8){1'b0}}, rd_sh[7:0]};
      3'b101:  ld_res = {{(DATA_W-16){1'b0}}, rd_sh[15:0]};
      default: ld_res = rd_sh;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_be       = '0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && (is_load || is_store)) begin
          if (req_bad) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            rdata_d      = '0;
          end else begin
            is_load_d = is_load;
            f3_d      = funct3;
            addr_d    = addr[DM_ADDRESS-1:0];
            wdata_d   = wdata;
            state_d   = ACC0;
          end
        end
      end
      ACC0: begin
        mem_req  = 1'b1;
        mem_addr = base_addr;
        if (!is_load_q) begin
          mem_we    = 1'b1;
          mem_be    = be_wide[3:0];
          mem_wdata = wd_wide[DATA_W-1:0];
        end
        state_d = cross_q ? ACC1 : FIN;
      end
      ACC1: begin
        mem_req  = 1'b1;
        mem_addr = base_addr + DM_ADDRESS'(4);
        if (!is_load_q) begin
          mem_we    = 1'b1;
          mem_be    = be_wide[7:4];
          mem_wdata = wd_wide[2*DATA_W-1:DATA_W];
        end
        lo_d    = mem_rdata;
        state_d = FIN;
      end
      FIN: begin
        rdata_d      = is_load_q ? ld_res : '0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      is_load_q    <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: split and non-split instances, word memory model, response/access scoreboards.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_s = 1'b0, req_valid_n = 1'b0;
  logic        is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;

  logic        req_ready_s, resp_valid_s, resp_err_s, mem_req_s, mem_we_s;
  logic [31:0] rdata_s, mem_wdata_s, rd_s;
  logic [8:0]  mem_addr_s;
  logic [3:0]  mem_be_s;
  logic        req_ready_n, resp_valid_n, resp_err_n, mem_req_n, mem_we_n;
  logic [31:0] rdata_n, mem_wdata_n, rd_n;
  logic [8:0]  mem_addr_n;
  logic [3:0]  mem_be_n;

  always #5 clk = ~clk;

  lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .SPLIT_MISALIGNED(1'b1)) u_split (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_s), .req_ready(req_ready_s),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid_s), .resp_err(resp_err_s), .rdata(rdata_s),
    .mem_req(mem_req_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_be(mem_be_s),
    .mem_wdata(mem_wdata_s), .mem_rdata(rd_s));

  lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .SPLIT_MISALIGNED(1'b0)) u_nosplit (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_n), .req_ready(req_ready_n),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid_n), .resp_err(resp_err_n), .rdata(rdata_n),
    .mem_req(mem_req_n), .mem_we(mem_we_n), .mem_addr(mem_addr_n), .mem_be(mem_be_n),
    .mem_wdata(mem_wdata_n), .mem_rdata(rd_n));

  // Word memory with registered read, shared by both instances.
  logic [31:0] mem [0:127];
  logic        pl_en = 1'b0;
  logic [6:0]  pl_w = '0;
  logic [31:0] pl_d = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_w] <= pl_d;
    if (mem_req_s) begin
      if (mem_we_s) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_s[b]) mem[mem_addr_s[8:2]][8*b +: 8] <= mem_wdata_s[8*b +: 8];
      end else begin
        rd_s <= mem[mem_addr_s[8:2]];
      end
    end
    if (mem_req_n && !mem_we_n) rd_n <= mem[mem_addr_n[8:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct { logic [8:0] a; logic we; logic [3:0] be; logic [31:0] wd; } acc_t;
  typedef struct { logic err; logic [31:0] rd; int due; } resp_t;
  acc_t  acc_s[$], acc_n[$];
  resp_t exp_s[$], exp_n[$];
  acc_t  ea;
  resp_t er;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every memory access and response is popped and checked here.
  always @(negedge clk) begin
    if (mem_req_s) begin
      if (acc_s.size() == 0) chk("unexpected mem_req split", {31'b0, mem_req_s}, 32'd0);
      else begin
        ea = acc_s.pop_front();
        chk("split mem_addr", {23'b0, mem_addr_s}, {23'b0, ea.a});
        chk("split mem_we", {31'b0, mem_we_s}, {31'b0, ea.we});
        if (ea.we) begin
          chk("split mem_be", {28'b0, mem_be_s}, {28'b0, ea.be});
          chk("split mem_wdata", mem_wdata_s, ea.wd);
        end
      end
    end
    if (mem_req_n) begin
      if (acc_n.size() == 0) chk("unexpected mem_req nosplit", {31'b0, mem_req_n}, 32'd0);
      else begin
        ea = acc_n.pop_front();
        chk("nosplit mem_addr", {23'b0, mem_addr_n}, {23'b0, ea.a});
        chk("nosplit mem_we", {31'b0, mem_we_n}, {31'b0, ea.we});
      end
    end
    if (resp_valid_s) begin
      if (exp_s.size() == 0) chk("spurious resp split", {31'b0, resp_valid_s}, 32'd0);
      else begin
        er = exp_s.pop_front();
        chk("split resp cycle", cyc, er.due);
        chk("split resp_err", {31'b0, resp_err_s}, {31'b0, er.err});
        chk("split rdata", rdata_s, er.rd);
      end
    end
    if (resp_valid_n) begin
      if (exp_n.size() == 0) chk("spurious resp nosplit", {31'b0, resp_valid_n}, 32'd0);
      else begin
        er = exp_n.pop_front();
        chk("nosplit resp cycle", cyc, er.due);
        chk("nosplit resp_err", {31'b0, resp_err_n}, {31'b0, er.err});
        chk("nosplit rdata", rdata_n, er.rd);
      end
    end
  end

  task automatic poke(input logic [6:0] w, input logic [31:0] d);
    pl_w = w; pl_d = d; pl_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic push_acc(input bit nos, input logic [8:0] a, input logic we,
                          input logic [3:0] be, input logic [31:0] wd);
    acc_t x;
    x.a = a; x.we = we; x.be = be; x.wd = wd;
    if (nos) acc_n.push_back(x); else acc_s.push_back(x);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic issue(input bit nos, input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input bit has_resp,
                       input logic e, input logic [31:0] rd, input int lat);
    resp_t r;
    int    n = 0;
    while (((nos ? req_ready_n : req_ready_s) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("req_ready timeout", {31'b0, nos ? req_ready_n : req_ready_s}, 32'd1);
    is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    if (nos) req_valid_n = 1'b1; else req_valid_s = 1'b1;
    if (has_resp) begin
      r.err = e; r.rd = rd; r.due = cyc + lat;
      if (nos) exp_n.push_back(r); else exp_s.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid_s = 1'b0;
    req_valid_n = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 128; i++) poke(7'(i), 32'd0);
    chk("reset resp_valid", {31'b0, resp_valid_s}, 32'd0);
    chk("reset resp_err", {31'b0, resp_err_s}, 32'd0);
    chk("reset rdata", rdata_s, 32'd0);
    chk("reset mem_req", {31'b0, mem_req_s}, 32'd0);
    chk("reset mem_we", {31'b0, mem_we_s}, 32'd0);
    chk("reset mem_addr", {23'b0, mem_addr_s}, 32'd0);
    chk("reset mem_be", {28'b0, mem_be_s}, 32'd0);
    chk("reset mem_wdata", mem_wdata_s, 32'd0);
    chk("reset nosplit rdata", rdata_n, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", {31'b0, req_ready_s}, 32'd1);

    poke(7'd4, 32'hDEADBEEF);
    poke(7'd5, 32'h000000CC);
    poke(7'd2, 32'h12345678);

    // Aligned loads with sign/zero extension
    push_acc(0, 9'h010, 1'b0, 4'h0, 32'h0);
    issue(0, 1, 0, 3'b010, 32'h10, 32'h0, 1, 1'b0, 32'hDEADBEEF, 3);
    repeat (4) @(negedge clk);
    poke(7'd4, 32'h80112233);
    push_acc(0, 9'h010, 1'b0, 4'h0, 32'h0);
    issue(0, 1, 0, 3'b000, 32'h13, 32'h0, 1, 1'b0, 32'hFFFFFF80, 3);
    push_acc(0, 9'h010, 1'b0, 4'h0, 32'h0);
    issue(0, 1, 0, 3'b100, 32'h13, 32'h0, 1, 1'b0, 32'h00000080, 3);

    // Halfword store to upper lanes, read back signed and unsigned
    push_acc(0, 9'h00C, 1'b1, 4'b1100, 32'hABCD0000);
    issue(0, 0, 1, 3'b001, 32'h0E, 32'h0000ABCD, 1, 1'b0, 32'h0, 3);
    push_acc(0, 9'h00C, 1'b0, 4'h0, 32'h0);
    issue(0, 1, 0, 3'b010, 32'h0C, 32'h0, 1, 1'b0, 32'hABCD0000, 3);
    push_acc(0, 9'h00C, 1'b0, 4'h0, 32'h0);
    issue(0, 1, 0, 3'b001, 32'h0E, 32'h0, 1, 1'b0, 32'hFFFFABCD, 3);
    push_acc(0, 9'h00C, 1'b0, 4'h0, 32'h0);
    issue(0, 1, 0, 3'b101, 32'h0E, 32'h0, 1, 1'b0, 32'h0000ABCD, 3);

    // Split store wrapping the top of memory, then split loads
    push_acc(0, 9'h1FC, 1'b1, 4'b1000, 32'h44000000);
    push_acc(0, 9'h000, 1'b1, 4'b0111, 32'h00112233);
    issue(0, 0, 1, 3'b010, 32'h1FF, 32'h11223344, 1, 1'b0, 32'h0, 4);
    push_acc(0, 9'h1FC, 1'b0, 4'h0, 32'h0);
    push_acc(0, 9'h000, 1'b0, 4'h0, 32'h0);
    issue(0, 1, 0, 3'b010, 32'h1FF, 32'h0, 1, 1'b0, 32'h11223344, 4);
    push_acc(0, 9'h010, 1'b0, 4'h0, 32'h0);
    push_acc(0, 9'h014, 1'b0, 4'h0, 32'h0);
    issue(0, 1, 0, 3'b001, 32'h13, 32'h0, 1, 1'b0, 32'hFFFFCC80, 4);

    // Illegal requests: no access, error response next cycle
    issue(0, 1, 1, 3'b010, 32'h10, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(0, 0, 1, 3'b100, 32'h10, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(0, 1, 0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(0, 1, 0, 3'b110, 32'h10, 32'h0, 1, 1'b1, 32'h0, 1);

    // Neither flag: ignored entirely
    issue(0, 0, 0, 3'b010, 32'h10, 32'h0, 0, 1'b0, 32'h0, 0);
    repeat (4) @(negedge clk);
    chk("ready after ignored req", {31'b0, req_ready_s}, 32'd1);

    // Non-split instance: crossing is an error, aligned works
    issue(1, 1, 0, 3'b010, 32'h06, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(1, 1, 1, 3'b010, 32'h08, 32'h0, 1, 1'b1, 32'h0, 1);
    push_acc(1, 9'h008, 1'b0, 4'h0, 32'h0);
    issue(1, 1, 0, 3'b010, 32'h08, 32'h0, 1, 1'b0, 32'h12345678, 3);
    repeat (4) @(negedge clk);

    // Reset during ACC1 of a split load
    push_acc(0, 9'h1FC, 1'b0, 4'h0, 32'h0);
    issue(0, 1, 0, 3'b010, 32'h1FE, 32'h0, 0, 1'b0, 32'h0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-reset mem_req", {31'b0, mem_req_s}, 32'd0);
    chk("mid-reset resp_valid", {31'b0, resp_valid_s}, 32'd0);
    chk("mid-reset req_ready", {31'b0, req_ready_s}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_acc(0, 9'h010, 1'b0, 4'h0, 32'h0);
    issue(0, 1, 0, 3'b010, 32'h10, 32'h0, 1, 1'b0, 32'h80112233, 3);

    repeat (8) @(negedge clk);
    chk("rdata hold", rdata_s, 32'h80112233);
    chk("pending resp split", exp_s.size(), 32'd0);
    chk("pending resp nosplit", exp_n.size(), 32'd0);
    chk("pending acc split", acc_s.size(), 32'd0);
    chk("pending acc nosplit", acc_n.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
